imem_boot_loader: RTL and testbench

- Boot-time writer for the single-cycle core's instruction memory.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words into instruction memory starting at byte address 0 and checks a payload checksum.
- Releases the core's reset only after a good frame. The core's rst stays active-low; only this block's own reset is active-high.

---
 rtl/boot_pkg.sv | 22 ++
 rtl/imem_boot_loader_word_assembler.sv | 57 +++++
 rtl/imem_boot_loader.sv | 117 +++++++++++
 tb/tb_imem_boot_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM state encoding (HDR0=0 ... ERR=5)
//   CHK_INIT       : checksum accumulator start value
//   BYTES_PER_WORD : stream bytes per instruction word
// -----------------------------------------------------------------------------
package boot_pkg;

   typedef enum logic [2:0] {
      HDR0 = 3'd0,
      HDR1 = 3'd1,
      DATA = 3'd2,
      CHK  = 3'd3,
      RUN  = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam logic [7:0] CHK_INIT       = 8'h00;
   localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs accepted stream bytes into little-endian 32-bit words.
//   clk, rst      : clock, synchronous active-high reset (discards lane buffer)
//   i_en          : a payload byte is accepted this cycle
//   i_byte        : the payload byte
//   o_last        : the byte accepted now (if any) completes a word (lane 3)
//   o_word_valid  : one-cycle pulse, the cycle after the lane-3 byte
//   o_word        : completed word, valid while o_word_valid is high
// -----------------------------------------------------------------------------
module word_assembler
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic        o_last,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   logic [LANE_W-1:0] r_lane;
   logic [2:0][7:0]   r_buf;     // lanes 0..2; lane 3 goes straight to r_word
   logic [31:0]       r_word;
   logic              r_valid;

   assign o_last = (r_lane == LANE_W'(BYTES_PER_WORD - 1));

   // The completed word is snapshotted into r_word so the next word's lane 0
   // may be accepted in the same cycle the previous word is being written.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane  <= '0;
         r_buf   <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (i_en) begin
            r_lane <= r_lane + 1'b1;
            if (o_last) begin
               r_word  <= {i_byte, r_buf[2], r_buf[1], r_buf[0]};
               r_valid <= 1'b1;
            end else begin
               r_buf[r_lane] <= i_byte;
            end
         end
      end
   end

   assign o_word_valid = r_valid;
   assign o_word       = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Loads a framed byte stream (N_lo, N_hi, 4N payload bytes, XOR checksum) into
// instruction memory from byte address 0 and releases the core after a good
// frame.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : byte stream handshake, in_data is the byte
//   imem_we/addr/wdata : instruction memory write port, one strobe per word
//   core_rst        : core reset, active low (1 = core running)
//   done            : frame verified, core released
//   error           : frame rejected (sticky until rst)
//   words_loaded    : words written so far
// -----------------------------------------------------------------------------
module imem_boot_loader
   import boot_pkg::*;
#(
   parameter int MAX_WORDS = 1024,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             imem_we,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic             core_rst,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   state_t           r_state, w_next;
   logic [7:0]       r_n_lo;
   logic [15:0]      r_n;
   logic [7:0]       r_chk;
   logic [CNT_W-1:0] r_words;
   logic             r_done, r_error, r_core_rst;

   logic             w_xfer;
   logic [15:0]      w_n_hdr;
   logic             w_last;
   logic             w_word_valid;
   logic [31:0]      w_word;

   assign in_ready = (r_state == HDR0) || (r_state == HDR1) ||
                     (r_state == DATA) || (r_state == CHK);
   assign w_xfer   = in_valid & in_ready;
   assign w_n_hdr  = {in_data, r_n_lo};

   word_assembler u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_en         (w_xfer && (r_state == DATA)),
      .i_byte       (in_data),
      .o_last       (w_last),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= HDR0;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         HDR0: if (w_xfer) w_next = HDR1;
         HDR1: if (w_xfer) begin
            if (int'(w_n_hdr) > MAX_WORDS) w_next = ERR;
            else if (w_n_hdr == 16'd0)     w_next = CHK;
            else                           w_next = DATA;
         end
         // The previous word's counter increment lands at least three cycles
         // before the next lane-3 byte, so r_words is current here.
         DATA: if (w_xfer && w_last && ((r_words + 1'b1) == CNT_W'(r_n)))
            w_next = CHK;
         CHK:  if (w_xfer) w_next = (in_data == r_chk) ? RUN : ERR;
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_lo     <= '0;
         r_n        <= '0;
         r_chk      <= CHK_INIT;
         r_words    <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_core_rst <= 1'b0;
      end else begin
         if (r_state == HDR0 && w_xfer) r_n_lo <= in_data;
         if (r_state == HDR1 && w_xfer) r_n    <= w_n_hdr;
         if (r_state == DATA && w_xfer) r_chk  <= r_chk ^ in_data;
         if (w_word_valid)              r_words <= r_words + 1'b1;
         if (w_next == RUN && r_state != RUN) begin
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
         end
         if (w_next == ERR && r_state != ERR) r_error <= 1'b1;
      end
   end

   // Address uses the pre-increment count: r_words advances at the end of
   // the same cycle the strobe is high.
   assign imem_we      = w_word_valid;
   assign imem_wdata   = w_word;
   assign imem_addr    = 32'(r_words) << 2;
   assign words_loaded = r_words;
   assign done         = r_done;
   assign error        = r_error;
   assign core_rst     = r_core_rst;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Scoreboard bench: stimulus pushes each expected memory write (address, data,
// cycle) when it sends a lane-3 payload byte; a monitor pops and compares on
// every imem_we. End-of-frame status is checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   imem_boot_loader #(.MAX_WORDS(1024), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin : mon
      wr_t e;
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%h data=%h want none", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", imem_addr, e.addr);
            chk("wr_data", imem_wdata, e.data);
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   // Drive one byte for one cycle; it transfers on the next rising edge if
   // in_ready is high, and a lane-3 byte must be written one cycle later.
   task automatic send(input logic [7:0] b, input bit lane3,
                       input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready && lane3) exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
   endtask

   task automatic send_frame(input logic [7:0] fr[$], input logic [31:0] w[$],
                             input bit toggle, input int stop);
      int p;
      for (int i = 0; i < fr.size(); i++) begin
         if (stop >= 0 && i >= stop) break;
         p = i - 2;
         if (p >= 0 && p < 4 * w.size() && (p % 4) == 3)
            send(fr[i], 1'b1, 32'(4 * (p / 4)), w[p / 4]);
         else
            send(fr[i], 1'b0, 32'h0, 32'h0);
         if (toggle) idle();
      end
      idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_we",       32'(imem_we), 32'd0);
      chk("rst_addr",     imem_addr, 32'd0);
      chk("rst_wdata",    imem_wdata, 32'd0);
      chk("rst_core_rst", 32'(core_rst), 32'd0);
      chk("rst_done",     32'(done), 32'd0);
      chk("rst_error",    32'(error), 32'd0);
      chk("rst_words",    32'(words_loaded), 32'd0);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic check_end(input string tag, input bit exp_done,
                            input bit exp_err, input int exp_words);
      repeat (3) @(negedge clk);
      chk({tag, "_done"},     32'(done), 32'(exp_done));
      chk({tag, "_core_rst"}, 32'(core_rst), 32'(exp_done));
      chk({tag, "_error"},    32'(error), 32'(exp_err));
      chk({tag, "_words"},    32'(words_loaded), 32'(exp_words));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_pending"},  32'(exp_q.size()), 32'd0);
   endtask

   logic [7:0]  good[$];
   logic [7:0]  badck[$];
   logic [7:0]  empty[$];
   logic [7:0]  big[$];
   logic [31:0] words[$];
   logic [31:0] nowords[$];

   initial begin
      good    = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00,
                  8'h13, 8'h03, 8'h30, 8'h00, 8'hE1};
      badck   = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00,
                  8'h13, 8'h03, 8'h30, 8'h00, 8'hE0};
      empty   = '{8'h00, 8'h00, 8'h00};
      big     = '{8'h01, 8'h04};
      words   = '{32'h00500293, 32'h00300313};
      nowords = {};
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // 1: good frame, back-to-back bytes
      do_reset();
      send_frame(good, words, 1'b0, -1);
      check_end("good", 1'b1, 1'b0, 2);

      // 2: bad checksum
      do_reset();
      send_frame(badck, words, 1'b0, -1);
      check_end("badck", 1'b0, 1'b1, 2);

      // 3: zero-length frame; release lands one cycle after the checksum
      do_reset();
      send_frame(empty, nowords, 1'b0, -1);
      chk("empty_done_now", 32'(done), 32'd1);
      chk("empty_crst_now", 32'(core_rst), 32'd1);
      check_end("empty", 1'b1, 1'b0, 0);

      // 4: N=1025 rejected right after the second header byte
      do_reset();
      send_frame(big, nowords, 1'b0, -1);
      chk("big_error_now", 32'(error), 32'd1);
      chk("big_ready_now", 32'(in_ready), 32'd0);
      send(8'hAA, 1'b0, 32'h0, 32'h0);
      idle();
      check_end("big", 1'b0, 1'b1, 0);

      // 5: good frame with in_valid toggling
      do_reset();
      send_frame(good, words, 1'b1, -1);
      check_end("toggle", 1'b1, 1'b0, 2);

      // 6: reset after 6 payload bytes, then full resend
      do_reset();
      send_frame(good, words, 1'b0, 8);
      idle();
      chk("partial_words", 32'(words_loaded), 32'd1);
      do_reset();
      repeat (3) idle();
      send_frame(good, words, 1'b0, -1);
      check_end("resend", 1'b1, 1'b0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
